bcd_updown_counter: RTL and testbench



---
 rtl/bcd_pkg.sv | 33 +++
 rtl/bcd_digit_updown.sv | 33 +++
 rtl/bcd_updown_counter.sv | 102 ++++++++++
 tb/tb_bcd_updown_counter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the up/down counter slice.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam int MAX_DIGITS = 16;

    // Packs a non-negative integer into up to 16 BCD digits, least significant digit in [3:0].
    function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int value);
        logic [4*MAX_DIGITS-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input bcd_digit_t digit);
        return digit <= BCD_MAX_DIGIT;
    endfunction

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One BCD digit of the ripple chain: steps up or down by cin, passing carry/borrow onward.
module bcd_digit_updown
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    input  logic       up,
    input  logic       dn,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);

    always_comb begin
        q    = d;
        cout = 1'b0;
        if (cin && up) begin
            if (d >= BCD_MAX_DIGIT) begin
                q    = 4'd0;
                cout = 1'b1;
            end else begin
                q = d + 4'd1;
            end
        end else if (cin && dn) begin
            if (d == 4'd0) begin
                q    = BCD_MAX_DIGIT;
                cout = 1'b1;
            end else begin
                q = d - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit registered BCD up/down counter with programmable terminal count,
// wrap or saturate at the range ends, validated parallel load and event pulses.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int NDIGITS  = 2,
    parameter int TERM     = 99,
    parameter bit SATURATE = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   ld,
    input  logic [4*NDIGITS-1:0]   ld_val,
    input  logic                   inc,
    input  logic                   dec,
    output logic [4*NDIGITS-1:0]   cnt,
    output logic                   at_max,
    output logic                   at_zero,
    output logic                   ovf,
    output logic                   unf,
    output logic                   ld_err
);

    localparam int W = 4 * NDIGITS;
    localparam logic [4*MAX_DIGITS-1:0] TERM_BCD_FULL = to_bcd(TERM);
    localparam logic [W-1:0] TERM_BCD = TERM_BCD_FULL[W-1:0];

    if (NDIGITS < 1 || NDIGITS > MAX_DIGITS || TERM < 1 ||
        longint'(TERM) > pow10(NDIGITS) - 1) begin : g_bad_params
        $fatal(1, "bcd_updown_counter: TERM out of range for NDIGITS");
    end

    logic             inc_only;
    logic             dec_only;
    logic [W-1:0]     step;
    logic [NDIGITS:0] carry;
    logic [NDIGITS-1:0] digit_ok;
    logic             ld_ok;
    logic             inc_at_end;
    logic             dec_at_end;

    assign inc_only = inc && !dec;
    assign dec_only = dec && !inc;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
        bcd_digit_updown u_digit (
            .d    (cnt[4*i +: 4]),
            .up   (inc_only),
            .dn   (dec_only),
            .cin  (carry[i]),
            .q    (step[4*i +: 4]),
            .cout (carry[i+1])
        );
        assign digit_ok[i] = bcd_valid(ld_val[4*i +: 4]);
    end

    assign at_max  = (cnt == TERM_BCD);
    assign at_zero = (cnt == '0);

    // With all digits valid, BCD ordering equals unsigned binary ordering.
    assign ld_ok = (&digit_ok) && (ld_val <= TERM_BCD);

    // A carry out of the top digit can only occur at the range ends; it guards the all-nines case.
    assign inc_at_end = at_max  || carry[NDIGITS];
    assign dec_at_end = at_zero || carry[NDIGITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            ld_err <= 1'b0;
        end else begin
            ovf    <= 1'b0;
            unf    <= 1'b0;
            ld_err <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (ld) begin
                if (ld_ok) cnt <= ld_val;
                else       ld_err <= 1'b1;
            end else if (inc_only) begin
                if (inc_at_end) begin
                    ovf <= 1'b1;
                    if (!SATURATE) cnt <= '0;
                end else begin
                    cnt <= step;
                end
            end else if (dec_only) begin
                if (dec_at_end) begin
                    unf <= 1'b1;
                    if (!SATURATE) cnt <= TERM_BCD;
                end else begin
                    cnt <= step;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: default, game-score (TERM=21 saturating) and 4-digit counters on shared stimulus.
module tb_bcd_updown_counter;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        ld;
    logic [15:0] ld_val;
    logic        inc;
    logic        dec;

    logic [7:0]  d_cnt;
    logic        d_max, d_zero, d_ovf, d_unf, d_err;
    logic [7:0]  s_cnt;
    logic        s_max, s_zero, s_ovf, s_unf, s_err;
    logic [15:0] w_cnt;
    logic        w_max, w_zero, w_ovf, w_unf, w_err;

    int checks;
    int failures;

    bcd_updown_counter u_def (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val[7:0]),
        .inc(inc), .dec(dec), .cnt(d_cnt), .at_max(d_max), .at_zero(d_zero),
        .ovf(d_ovf), .unf(d_unf), .ld_err(d_err)
    );

    bcd_updown_counter #(.NDIGITS(2), .TERM(21), .SATURATE(1'b1)) u_score (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val[7:0]),
        .inc(inc), .dec(dec), .cnt(s_cnt), .at_max(s_max), .at_zero(s_zero),
        .ovf(s_ovf), .unf(s_unf), .ld_err(s_err)
    );

    bcd_updown_counter #(.NDIGITS(4), .TERM(9999), .SATURATE(1'b0)) u_wide (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val),
        .inc(inc), .dec(dec), .cnt(w_cnt), .at_max(w_max), .at_zero(w_zero),
        .ovf(w_ovf), .unf(w_unf), .ld_err(w_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       ld;
        logic       inc;
        logic       dec;
        logic [7:0] ld_val;
        logic [7:0] exp_cnt;
        logic       exp_ovf;
        logic       exp_unf;
        logic       exp_err;
        logic       exp_zero;
        logic       exp_max;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // driver: apply one cycle of inputs, then sample 1 time unit after the edge
    task automatic drive(input logic c, input logic l, input logic i, input logic d, input logic [15:0] v);
        clr = c; ld = l; inc = i; dec = d; ld_val = v;
        @(posedge clk);
        #1;
        clr = 1'b0; ld = 1'b0; inc = 1'b0; dec = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] bcd2(input int k);
        return {4'(k / 10), 4'(k % 10)};
    endfunction

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; clr = 1'b0; ld = 1'b0; inc = 1'b0; dec = 1'b0; ld_val = '0;

        //            clr  ld   inc  dec  ld_val  cnt    ovf  unf  err  zero max
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b1,8'h00,  8'h99, 1'b0,1'b1,1'b0,1'b0,1'b1};
        vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,8'h10,  8'h10, 1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,8'h00,  8'h09, 1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,8'h3A,  8'h09, 1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,8'h42,  8'h42, 1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,8'h17,  8'h00, 1'b0,1'b0,1'b0,1'b1,1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,8'h42,  8'h42, 1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b1,8'h00,  8'h42, 1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,8'h00,  8'h43, 1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,8'h99,  8'h99, 1'b0,1'b0,1'b0,1'b0,1'b1};
        vecs[10] = '{1'b0,1'b0,1'b1,1'b0,8'h00,  8'h00, 1'b1,1'b0,1'b0,1'b1,1'b0};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,8'h00,  8'h00, 1'b0,1'b0,1'b0,1'b1,1'b0};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b1,8'h00,  8'h00, 1'b0,1'b0,1'b0,1'b1,1'b0};

        // reset state
        do_reset();
        check("rst_def_cnt", 16'(d_cnt), 16'h00);
        check("rst_def_flags", {11'b0, d_zero, d_max, d_ovf, d_unf, d_err}, 16'b10000);
        check("rst_score_cnt", 16'(s_cnt), 16'h00);
        check("rst_wide_cnt", w_cnt, 16'h0000);
        check("rst_wide_flags", {11'b0, w_zero, w_max, w_ovf, w_unf, w_err}, 16'b10000);

        // walk 0..99 then wrap with ovf
        for (int k = 1; k <= 100; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
            check("walk_cnt", 16'(d_cnt), 16'(bcd2(k % 100)));
            check("walk_max", 16'(d_max), 16'(k == 99));
            check("walk_ovf", 16'(d_ovf), 16'(k == 100));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("walk_ovf_drop", 16'(d_ovf), 16'h0);

        // table-driven vectors on the default counter
        do_reset();
        for (int n = 0; n < 13; n++) begin
            drive(vecs[n].clr, vecs[n].ld, vecs[n].inc, vecs[n].dec, 16'(vecs[n].ld_val));
            check($sformatf("vec%0d_cnt", n), 16'(d_cnt), 16'(vecs[n].exp_cnt));
            check($sformatf("vec%0d_flags", n),
                  {11'b0, d_ovf, d_unf, d_err, d_zero, d_max},
                  {11'b0, vecs[n].exp_ovf, vecs[n].exp_unf, vecs[n].exp_err,
                   vecs[n].exp_zero, vecs[n].exp_max});
        end

        // rst wins over a simultaneous load
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0055);
        rst = 1'b0;
        check("rst_ld_cnt", 16'(d_cnt), 16'h00);
        check("rst_ld_err", 16'(d_err), 16'h0);

        // game score: saturate at 21
        for (int s = 1; s <= 25; s++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
            check("score_cnt", 16'(s_cnt), 16'(bcd2(s < 21 ? s : 21)));
            check("score_ovf", 16'(s_ovf), 16'(s >= 22));
            check("score_max", 16'(s_max), 16'(s >= 21));
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0025);
        check("score_ld25_cnt", 16'(s_cnt), 16'h21);
        check("score_ld25_err", 16'(s_err), 16'h1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0017);
        check("score_ld17_cnt", 16'(s_cnt), 16'h17);
        check("score_ld17_err", 16'(s_err), 16'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h003A);
        check("score_ld3a_cnt", 16'(s_cnt), 16'h17);
        check("score_ld3a_err", 16'(s_err), 16'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("score_err_drop", 16'(s_err), 16'h0);
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        check("score_unf_hold_cnt", 16'(s_cnt), 16'h00);
        check("score_unf_pulse", 16'(s_unf), 16'h1);

        // four-digit ripple carries
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0999);
        check("wide_ld", w_cnt, 16'h0999);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        check("wide_inc_ripple", w_cnt, 16'h1000);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        check("wide_dec_ripple", w_cnt, 16'h0999);
        check("wide_no_unf", 16'(w_unf), 16'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0109);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        check("wide_inc_0109", w_cnt, 16'h0110);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h9999);
        check("wide_ld_max", {15'b0, w_max}, 16'h1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        check("wide_wrap_cnt", w_cnt, 16'h0000);
        check("wide_wrap_ovf", 16'(w_ovf), 16'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        check("wide_unf_cnt", w_cnt, 16'h9999);
        check("wide_unf_pulse", 16'(w_unf), 16'h1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h12A4);
        check("wide_bad_digit_cnt", w_cnt, 16'h9999);
        check("wide_bad_digit_err", 16'(w_err), 16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
